// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB request arbiter: FSM encoding, protection
// field width and the default BUSY timeout.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int PROT_W          = 3;
    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after
// rr_ptr (wrapping modulo NREQ) wins.
module rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any_req
);

    int cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any_req  = 1'b0;
        cand     = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (!any_req && req[cand]) begin
                any_req    = 1'b1;
                pick_idx   = IDX_W'(cand);
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sharing of one APB master between NREQ requesters.
// Optional BUSY abort after TIMEOUT cycles when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            s_write,
    input  logic [NREQ*ADDR_W-1:0]     s_addr,
    input  logic [NREQ*DATA_W-1:0]     s_wdata,
    input  logic [NREQ*DATA_W/8-1:0]   s_strb,
    input  logic [NREQ*PROT_W-1:0]     s_prot,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [DATA_W-1:0]          rdata,
    output logic                       slverr,
    output logic                       transfer,
    output logic                       SWRITE,
    output logic [ADDR_W-1:0]          SADDR,
    output logic [DATA_W-1:0]          SWDATA,
    output logic [DATA_W/8-1:0]        SSTRB,
    output logic [PROT_W-1:0]          SPROT,
    input  logic                       m_done,
    input  logic [DATA_W-1:0]          m_rdata,
    input  logic                       m_slverr
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];
    logic [STRB_W-1:0] strb_arr  [NREQ];
    logic [PROT_W-1:0] prot_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = s_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = s_wdata[gi*DATA_W +: DATA_W];
        assign strb_arr[gi]  = s_strb[gi*STRB_W +: STRB_W];
        assign prot_arr[gi]  = s_prot[gi*PROT_W +: PROT_W];
    end

    arb_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]  owner_reg, owner_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              slverr_reg, slverr_next;
    logic              transfer_reg, transfer_next;
    logic              swrite_reg, swrite_next;
    logic [ADDR_W-1:0] saddr_reg, saddr_next;
    logic [DATA_W-1:0] swdata_reg, swdata_next;
    logic [STRB_W-1:0] sstrb_reg, sstrb_next;
    logic [PROT_W-1:0] sprot_reg, sprot_next;

    logic [NREQ-1:0]   pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              any_req;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr_reg),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_reg, tmo_cnt_next;
    logic       tmo_hit;

    // Counter holds the number of completed BUSY cycles, so TIMEOUT-1 means
    // this is the TIMEOUT-th BUSY cycle.
    assign tmo_hit = (tmo_cnt_reg == 8'(TIMEOUT - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) tmo_cnt_reg <= '0;
        else        tmo_cnt_reg <= tmo_cnt_next;
    end
`endif

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        owner_next    = owner_reg;
        gnt_next      = gnt_reg;
        done_next     = '0;
        rdata_next    = rdata_reg;
        slverr_next   = slverr_reg;
        transfer_next = transfer_reg;
        swrite_next   = swrite_reg;
        saddr_next    = saddr_reg;
        swdata_next   = swdata_reg;
        sstrb_next    = sstrb_reg;
        sprot_next    = sprot_reg;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_next  = tmo_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    owner_next    = pick_idx;
                    gnt_next      = pick;
                    transfer_next = 1'b1;
                    swrite_next   = s_write[pick_idx];
                    saddr_next    = addr_arr[pick_idx];
                    swdata_next   = wdata_arr[pick_idx];
                    // Reads must present all-zero strobes on the bus.
                    sstrb_next    = s_write[pick_idx] ? strb_arr[pick_idx] : '0;
                    sprot_next    = prot_arr[pick_idx];
                    state_next    = BUSY;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt_next  = '0;
`endif
                end
            end
            BUSY: begin
`ifdef APB_ARB_TIMEOUT_EN
                tmo_cnt_next = tmo_cnt_reg + 8'd1;
`endif
                if (m_done) begin
                    rdata_next    = m_rdata;
                    slverr_next   = m_slverr;
                    transfer_next = 1'b0;
                    done_next     = gnt_reg;
                    state_next    = RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_next    = '0;
                    slverr_next   = 1'b1;
                    transfer_next = 1'b0;
                    done_next     = gnt_reg;
                    state_next    = RESP;
                end
`endif
            end
            RESP: begin
                rr_ptr_next = (owner_reg == IDX_W'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
                gnt_next    = '0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            rdata_reg    <= '0;
            slverr_reg   <= 1'b0;
            transfer_reg <= 1'b0;
            swrite_reg   <= 1'b0;
            saddr_reg    <= '0;
            swdata_reg   <= '0;
            sstrb_reg    <= '0;
            sprot_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            owner_reg    <= owner_next;
            gnt_reg      <= gnt_next;
            done_reg     <= done_next;
            rdata_reg    <= rdata_next;
            slverr_reg   <= slverr_next;
            transfer_reg <= transfer_next;
            swrite_reg   <= swrite_next;
            saddr_reg    <= saddr_next;
            swdata_reg   <= swdata_next;
            sstrb_reg    <= sstrb_next;
            sprot_reg    <= sprot_next;
        end
    end

    assign gnt      = gnt_reg;
    assign done     = done_reg;
    assign rdata    = rdata_reg;
    assign slverr   = slverr_reg;
    assign transfer = transfer_reg;
    assign SWRITE   = swrite_reg;
    assign SADDR    = saddr_reg;
    assign SWDATA   = swdata_reg;
    assign SSTRB    = sstrb_reg;
    assign SPROT    = sprot_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table plus hand sequences
// for round-robin, mid-transfer reset and (with APB_ARB_TIMEOUT_EN) timeout.
module tb_apb_req_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int TO   = 16;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   s_write;
    logic [NREQ*AW-1:0] s_addr;
    logic [NREQ*DW-1:0] s_wdata;
    logic [NREQ*SW-1:0] s_strb;
    logic [NREQ*3-1:0] s_prot;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     rdata;
    logic              slverr;
    logic              transfer;
    logic              SWRITE;
    logic [AW-1:0]     SADDR;
    logic [DW-1:0]     SWDATA;
    logic [SW-1:0]     SSTRB;
    logic [2:0]        SPROT;
    logic              m_done;
    logic [DW-1:0]     m_rdata;
    logic              m_slverr;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req      (req),
        .s_write  (s_write),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_strb   (s_strb),
        .s_prot   (s_prot),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .slverr   (slverr),
        .transfer (transfer),
        .SWRITE   (SWRITE),
        .SADDR    (SADDR),
        .SWDATA   (SWDATA),
        .SSTRB    (SSTRB),
        .SPROT    (SPROT),
        .m_done   (m_done),
        .m_rdata  (m_rdata),
        .m_slverr (m_slverr)
    );

    typedef struct {
        int         idx;
        bit         wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] mrd;
        bit         merr;
        logic [3:0]  exp_strb;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        bit          slverr;
    } exp_t;

    exp_t sb[$];
    vec_t vt[5];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
        end
    endtask

    task automatic load_cmd(input vec_t v);
        s_write[v.idx]           = v.wr;
        s_addr[v.idx*AW +: AW]   = v.addr;
        s_wdata[v.idx*DW +: DW]  = v.wdata;
        s_strb[v.idx*SW +: SW]   = v.strb;
        s_prot[v.idx*3 +: 3]     = v.prot;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},      64'(gnt), 64'd0);
        chk({tag, "_done"},     64'(done), 64'd0);
        chk({tag, "_rdata"},    64'(rdata), 64'd0);
        chk({tag, "_slverr"},   64'(slverr), 64'd0);
        chk({tag, "_transfer"}, 64'(transfer), 64'd0);
        chk({tag, "_swrite"},   64'(SWRITE), 64'd0);
        chk({tag, "_saddr"},    64'(SADDR), 64'd0);
        chk({tag, "_swdata"},   64'(SWDATA), 64'd0);
        chk({tag, "_sstrb"},    64'(SSTRB), 64'd0);
        chk({tag, "_sprot"},    64'(SPROT), 64'd0);
    endtask

    // Caller raises req; returns on the IDLE cycle after the done pulse.
    task automatic run_txn(input vec_t v, input bit hold, output int low);
        exp_t e;
        int   n;
        low = 0;
        n   = 0;
        @(negedge PCLK);
        while (transfer !== 1'b1 && n < 20) begin
            low++;
            n++;
            @(negedge PCLK);
        end
        chk("grant_seen", 64'(transfer), 64'd1);
        if (transfer !== 1'b1) return;
        chk("gnt",    64'(gnt), 64'd1 << v.idx);
        chk("saddr",  64'(SADDR), 64'(v.addr));
        chk("swdata", 64'(SWDATA), 64'(v.wdata));
        chk("sstrb",  64'(SSTRB), 64'(v.exp_strb));
        chk("swrite", 64'(SWRITE), 64'(v.wr));
        chk("sprot",  64'(SPROT), 64'(v.prot));
        chk("early_done", 64'(done), 64'd0);
        e.idx = v.idx; e.rdata = v.mrd; e.slverr = v.merr;
        sb.push_back(e);
        @(negedge PCLK);
        chk("busy_transfer", 64'(transfer), 64'd1);
        chk("busy_saddr",    64'(SADDR), 64'(v.addr));
        chk("busy_sstrb",    64'(SSTRB), 64'(v.exp_strb));
        m_done = 1'b1; m_rdata = v.mrd; m_slverr = v.merr;
        @(negedge PCLK);
        m_done = 1'b0; m_rdata = '0; m_slverr = 1'b0;
        e = sb.pop_front();
        chk("done",          64'(done), 64'd1 << e.idx);
        chk("rdata",         64'(rdata), 64'(e.rdata));
        chk("slverr",        64'(slverr), 64'(e.slverr));
        chk("resp_transfer", 64'(transfer), 64'd0);
        chk("resp_gnt",      64'(gnt), 64'd1 << e.idx);
        $display("txn owner=%0d write=%0d addr=%h rdata=%h slverr=%0d",
                 v.idx, v.wr, v.addr, rdata, slverr);
        if (!hold) req[v.idx] = 1'b0;
        @(negedge PCLK);
        chk("idle_done",     64'(done), 64'd0);
        chk("idle_gnt",      64'(gnt), 64'd0);
        chk("idle_transfer", 64'(transfer), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rr0, rr1, r2v, r0b;
        int   low;
        int   n;

        vt[0] = '{0, 1'b1, 32'h000000ff, 32'h01010101, 4'hf, 3'd0, 32'h00000000, 1'b0, 4'hf};
        vt[1] = '{1, 1'b0, 32'h000002ff, 32'h00000000, 4'h9, 3'd2, 32'h880000bb, 1'b0, 4'h0};
        vt[2] = '{0, 1'b0, 32'h00001000, 32'h00000000, 4'hf, 3'd7, 32'hcafef00d, 1'b1, 4'h0};
        vt[3] = '{1, 1'b1, 32'h0000abcd, 32'h55aa55aa, 4'ha, 3'd2, 32'h00000000, 1'b0, 4'ha};
        vt[4] = '{2, 1'b1, 32'h00000033, 32'hdeadbeef, 4'h3, 3'd1, 32'h12345678, 1'b1, 4'h3};
        rr0   = '{0, 1'b1, 32'h00000100, 32'h11111111, 4'h1, 3'd0, 32'h00000000, 1'b0, 4'h1};
        rr1   = '{1, 1'b0, 32'h00000204, 32'h22222222, 4'hf, 3'd5, 32'ha5a5a5a5, 1'b0, 4'h0};
        r2v   = '{2, 1'b1, 32'h00000300, 32'h33333333, 4'hc, 3'd3, 32'h00000000, 1'b0, 4'hc};
        r0b   = '{0, 1'b1, 32'h00000404, 32'h44444444, 4'h6, 3'd4, 32'h0badf00d, 1'b0, 4'h6};

        req = '0; s_write = '0; s_addr = '0; s_wdata = '0; s_strb = '0; s_prot = '0;
        m_done = 1'b0; m_rdata = '0; m_slverr = 1'b0;

        repeat (3) @(negedge PCLK);
        chk_all_zero("reset");
        PRESET = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 5; i++) begin
            load_cmd(vt[i]);
            req[vt[i].idx] = 1'b1;
            run_txn(vt[i], 1'b0, low);
            chk("start_latency", 64'(low), 64'd0);
        end

        // m_done while IDLE must be ignored.
        m_done = 1'b1; m_rdata = 32'hffffffff; m_slverr = 1'b1;
        @(negedge PCLK);
        m_done = 1'b0; m_rdata = '0; m_slverr = 1'b0;
        chk("stray_mdone_done", 64'(done), 64'd0);
        chk("stray_mdone_transfer", 64'(transfer), 64'd0);
        @(negedge PCLK);
        chk("stray_mdone_done2", 64'(done), 64'd0);

        // Two requesters held continuously: grants alternate 0,1,0,1.
        load_cmd(rr0);
        load_cmd(rr1);
        req[0] = 1'b1;
        req[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn((k % 2 == 0) ? rr0 : rr1, 1'b1, low);
            chk("rr_gap", 64'(low), 64'd0);
        end
        req = '0;

        // Asynchronous reset in the middle of BUSY.
        load_cmd(r2v);
        req[2] = 1'b1;
        @(negedge PCLK);
        chk("pre_reset_transfer", 64'(transfer), 64'd1);
        chk("pre_reset_gnt", 64'(gnt), 64'd4);
        #2 PRESET = 1'b1;
        #1 chk_all_zero("async_reset");
        m_done = 1'b1; m_rdata = 32'h77777777;
        @(negedge PCLK);
        chk("reset_no_done", 64'(done), 64'd0);
        chk("reset_no_transfer", 64'(transfer), 64'd0);
        m_done = 1'b0; m_rdata = '0;
        load_cmd(r0b);
        req = '1;
        PRESET = 1'b0;
        run_txn(r0b, 1'b0, low);
        req = '0;
        repeat (3) @(negedge PCLK);
        chk("final_idle_transfer", 64'(transfer), 64'd0);
        chk("final_idle_done", 64'(done), 64'd0);

`ifdef APB_ARB_TIMEOUT_EN
        load_cmd(rr0);
        req[0] = 1'b1;
        @(negedge PCLK);
        chk("tmo_transfer", 64'(transfer), 64'd1);
        n = 0;
        while (done === '0 && n < TO + 10) begin
            @(negedge PCLK);
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'(TO));
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_slverr", 64'(slverr), 64'd1);
        chk("tmo_rdata", 64'(rdata), 64'd0);
        chk("tmo_transfer_low", 64'(transfer), 64'd0);
        $display("txn owner=0 timeout after %0d cycles slverr=%0d", n, slverr);
        req[0] = 1'b0;
        @(negedge PCLK);
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
